rs232_rx_fifo: RTL and testbench

//   Receive-side byte FIFO between the RS-232 receiver (RS232R) and the CPU I/O bus.

---
 rtl/rs232_rx_fifo_pkg.sv | 21 ++
 rtl/rs232_rx_fifo_mem_dp.sv | 28 ++
 rtl/rs232_rx_fifo.sv | 115 +++++++++++
 tb/tb_rs232_rx_fifo.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/rs232_rx_fifo_pkg.sv
// Shared constants for the RS-232 receive FIFO: CPU IO word indices, status bit
// positions and the default address width.
// Build option: RXFIFO_LEVEL_EN adds the entry count to status word RX_STAT.
package rs232_rx_fifo_pkg;

  // IO word indices on the CPU bus
  localparam int unsigned RX_DATA = 2;
  localparam int unsigned RX_STAT = 3;

  // Status word bit positions
  localparam int unsigned STAT_RDY       = 0;
  localparam int unsigned STAT_OVR       = 1;
  localparam int unsigned STAT_LEVEL_LSB = 3;

  // Default address width: 16-entry FIFO
  localparam int unsigned RXFIFO_AW = 4;

  // Byte width carried by the FIFO
  localparam int unsigned RX_DW = 8;

endpackage : rs232_rx_fifo_pkg

// File: rtl/rs232_rx_fifo_mem_dp.sv
// fifo_mem_dp: 2**AW x 8 distributed RAM, synchronous write, asynchronous read.
// No reset on the array so it maps onto LUT RAM.
module fifo_mem_dp #(
  parameter int unsigned AW = 4
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);

  localparam int unsigned DEPTH = 2**AW;

  logic [7:0] mem [DEPTH];

  // Write port: one byte per clock when enabled
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Asynchronous read port
  assign rdata = mem[raddr];

endmodule : fifo_mem_dp

// File: rtl/rs232_rx_fifo.sv
// rs232_rx_fifo: receive-side byte FIFO between RS232R and the CPU IO bus.
// Every byte flagged by the receiver is acked at once; a full FIFO drops the
// byte and sets a sticky overrun flag that the CPU clears via clr_ovr.
// Build option: RXFIFO_LEVEL_EN drives level_out with the entry count
// (otherwise level_out is tied to zero).
module rs232_rx_fifo
  import rs232_rx_fifo_pkg::*;
#(
  parameter int unsigned AW = RXFIFO_AW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          rx_rdy,
  input  logic [7:0]    rx_data,
  output logic          rx_done,
  input  logic          rd_pop,
  input  logic          clr_ovr,
  output logic [7:0]    data_out,
  output logic          rdy_out,
  output logic          ovr_out,
  output logic [AW:0]   level_out
);

  localparam int unsigned DEPTH = 2**AW;
  localparam int unsigned CW    = AW + 1;

  logic [AW-1:0] wr_ptr, wr_ptr_nxt;
  logic [AW-1:0] rd_ptr, rd_ptr_nxt;
  logic [CW-1:0] count, count_nxt;
  logic          ovr, ovr_nxt;

  logic          push;
  logic          pop;
  logic          full;
  logic          wr_en;
  logic [7:0]    mem_rdata;

  // Request decode: a pop needs data, a push is taken when room or a pop frees a slot
  always_comb begin
    push  = rx_rdy & rst;
    pop   = rd_pop & rst & (count != '0);
    full  = (count == CW'(DEPTH));
    wr_en = push & (~full | pop);
  end

  // Next-state for pointers, count and overrun flag
  always_comb begin
    wr_ptr_nxt = wr_ptr;
    rd_ptr_nxt = rd_ptr;
    count_nxt  = count;
    ovr_nxt    = ovr;

    if (wr_en) begin
      wr_ptr_nxt = wr_ptr + AW'(1);
    end
    if (pop) begin
      rd_ptr_nxt = rd_ptr + AW'(1);
    end

    unique case ({wr_en, pop})
      2'b10:   count_nxt = count + CW'(1);
      2'b01:   count_nxt = count - CW'(1);
      default: count_nxt = count;
    endcase

    // Overflow set has priority over a same-cycle clear
    if (clr_ovr) begin
      ovr_nxt = 1'b0;
    end
    if (push && !wr_en) begin
      ovr_nxt = 1'b1;
    end
  end

  // State registers with synchronous active-low reset; storage is left as-is
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovr    <= 1'b0;
    end else begin
      wr_ptr <= wr_ptr_nxt;
      rd_ptr <= rd_ptr_nxt;
      count  <= count_nxt;
      ovr    <= ovr_nxt;
    end
  end

  fifo_mem_dp #(
    .AW (AW)
  ) u_mem (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wr_ptr),
    .wdata (rx_data),
    .raddr (rd_ptr),
    .rdata (mem_rdata)
  );

  // Bus-facing outputs: ack, head byte and status straight from registered state
  always_comb begin
    rx_done  = rx_rdy & rst;
    rdy_out  = (count != '0);
    ovr_out  = ovr;
    data_out = rdy_out ? mem_rdata : 8'h00;
  end

`ifdef RXFIFO_LEVEL_EN
  assign level_out = count;
`else
  assign level_out = '0;
`endif

endmodule : rs232_rx_fifo

// File: tb/tb_rs232_rx_fifo.sv
// Self-checking bench for rs232_rx_fifo: directed scenarios plus random traffic
// against a queue-based reference model; popped bytes go through a scoreboard.
module tb_rs232_rx_fifo;

  localparam int unsigned AW    = 4;
  localparam int unsigned DEPTH = 2**AW;

  logic          clk;
  logic          rst;
  logic          rx_rdy;
  logic [7:0]    rx_data;
  logic          rx_done;
  logic          rd_pop;
  logic          clr_ovr;
  logic [7:0]    data_out;
  logic          rdy_out;
  logic          ovr_out;
  logic [AW:0]   level_out;

  int total = 0;
  int bad   = 0;

  // Reference model: FIFO contents and overrun flag
  logic [7:0] model_q[$];
  logic       ovr_m = 1'b0;
  // Scoreboard of bytes the CPU should see on each accepted pop
  logic [7:0] exp_q[$];

  rs232_rx_fifo #(.AW(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx_rdy    (rx_rdy),
    .rx_data   (rx_data),
    .rx_done   (rx_done),
    .rd_pop    (rd_pop),
    .clr_ovr   (clr_ovr),
    .data_out  (data_out),
    .rdy_out   (rdy_out),
    .ovr_out   (ovr_out),
    .level_out (level_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every pop the DUT honours must return the next scoreboard byte
  always @(negedge clk) begin
    if (rst === 1'b1 && rd_pop === 1'b1 && rdy_out === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("pop_unexpected", 32'(rdy_out), 32'd0);
      end else begin
        chk("pop_data", 32'(data_out), 32'(exp_q.pop_front()));
      end
    end
  end

  // One clock of stimulus; called just after a posedge, returns just after the next
  task automatic step(input logic r, input logic v, input logic [7:0] d,
                      input logic p, input logic c);
    int          sz;
    logic [7:0]  head;
    logic        ovr_pre;
    logic        took_pop;
    rst = r; rx_rdy = v; rx_data = d; rd_pop = p; clr_ovr = c;

    sz      = model_q.size();
    head    = (sz != 0) ? model_q[0] : 8'h00;
    ovr_pre = ovr_m;

    // Model update for the coming posedge
    if (!r) begin
      model_q.delete();
      ovr_m = 1'b0;
    end else begin
      took_pop = p && (sz != 0);
      if (took_pop) exp_q.push_back(model_q.pop_front());
      if (c) ovr_m = 1'b0;
      if (v) begin
        if (sz == DEPTH && !took_pop) ovr_m = 1'b1;
        else model_q.push_back(d);
      end
    end

    @(negedge clk);
    chk("rx_done", 32'(rx_done), 32'(v & r));
    chk("rdy_out", 32'(rdy_out), 32'(sz != 0));
    chk("ovr_out", 32'(ovr_out), 32'(ovr_pre));
    chk("data_out", 32'(data_out), 32'(head));
`ifdef RXFIFO_LEVEL_EN
    chk("level_out", 32'(level_out), 32'(sz));
`else
    chk("level_out", 32'(level_out), 32'd0);
`endif
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic push(input logic [7:0] d);
    step(1'b1, 1'b1, d, 1'b0, 1'b0);
  endtask

  task automatic pop1();
    step(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
  endtask

  initial begin
    rst = 1'b0; rx_rdy = 1'b1; rx_data = 8'h55; rd_pop = 1'b0; clr_ovr = 1'b0;
    // First edge brings registers out of X; checking starts afterwards
    @(posedge clk);
    #1;
    // Reset held with a byte offered: nothing acked, nothing stored
    step(1'b0, 1'b1, 8'h55, 1'b0, 1'b0);
    step(1'b0, 1'b1, 8'h66, 1'b0, 1'b0);

    // Single byte
    push(8'h41);
    idle(1);
    pop1();
    idle(1);

    // Order and wrap: 40 bytes, each popped three clocks after arrival
    for (int i = 0; i < 40; i++) begin
      push(8'(i));
      idle(2);
      pop1();
    end
    idle(1);

    // Overflow: 17 bytes into 16 entries
    for (int i = 0; i < 17; i++) push(8'(8'h10 + i));
    idle(1);
    for (int i = 0; i < DEPTH; i++) pop1();
    step(1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
    idle(1);

    // Full with simultaneous push and pop
    for (int i = 0; i < DEPTH; i++) push(8'(8'h80 + i));
    step(1'b1, 1'b1, 8'hAA, 1'b1, 1'b0);
    idle(1);
    for (int i = 0; i < DEPTH; i++) pop1();
    idle(1);

    // Pop on empty is ignored
    pop1();
    idle(1);

    // Overflow against a same-cycle clear: overflow wins
    for (int i = 0; i < DEPTH; i++) push(8'(8'hC0 + i));
    step(1'b1, 1'b1, 8'hEE, 1'b0, 1'b1);
    idle(1);
    for (int i = 0; i < DEPTH - 5; i++) pop1();
    // Reset with 5 entries left empties the FIFO
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    idle(1);
    pop1();

    // Random traffic with occasional resets
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 99) != 0),
           ($urandom_range(0, 99) < 55),
           8'($urandom),
           ($urandom_range(0, 99) < 40),
           ($urandom_range(0, 99) < 5));
    end
    // Drain
    step(1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < DEPTH + 1; i++) pop1();
    idle(2);

    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_rs232_rx_fifo
